core_mem_arb: RTL and testbench
===============================

Name: core_mem_arb

Overview:
- Parametrised successor to the fixed one-cycle memory glue in the softcore top level.
- Arbitrates a CPU data port (byte-addressed, with byte enables) and a host CSR port (word-addressed) onto one simple dual-port RAM (dp_ram style).
- Supports configurable RAM read latency, selectable arbitration mode, out-of-range address detection and an error counter.
- Sits between rv32i_cpu_core / core_csr_decode and a dp_ram instance.

Parameters:
- ADDR_WIDTH, 12: RAM word-address bits.
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- RD_LATENCY, 1: RAM read latency in cycles; legal range 1..4.
- HOST_PRIORITY, 1: 1 = host wins simultaneous requests; 0 = round-robin.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-low, sampled on clk
- cpu_address  in  32  CPU byte address
- cpu_read  in  1  CPU read request
- cpu_write  in  1  CPU write request
- cpu_writedata  in  DATA_WIDTH  CPU write data
- cpu_byteenable  in  DATA_WIDTH/8  CPU byte enables
- cpu_readdata  out  DATA_WIDTH  CPU read data
- cpu_waitrequest  out  1  Avalon waitrequest to CPU
- host_address  in  ADDR_WIDTH  host word address
- host_read  in  1  host read request
- host_write  in  1  host write request
- host_writedata  in  DATA_WIDTH  host write data
- host_readdata  out  DATA_WIDTH  host read data
- host_waitrequest  out  1  Avalon waitrequest to host
- ram_wren  out  1  RAM write enable
- ram_byteena  out  DATA_WIDTH/8  RAM byte enables
- ram_wraddress  out  ADDR_WIDTH  RAM write address
- ram_data  out  DATA_WIDTH  RAM write data
- ram_rdaddress  out  ADDR_WIDTH  RAM read address
- ram_q  in  DATA_WIDTH  RAM read data
- oor_clr  in  1  clears oor_count
- oor_count  out  16  saturating count of CPU out-of-range accesses

Behaviour:
- Localparams:
  - BE_W = DATA_WIDTH/8
  - A_LSB = clog2(BE_W)
  - CPU word index = cpu_address[ADDR_WIDTH+A_LSB-1:A_LSB]
- CPU out-of-range condition: any of cpu_address[31:ADDR_WIDTH+A_LSB] nonzero.
- Reset (reset_n low at a clk edge):
  - state -> IDLE, latency counter -> 0, rr pointer -> CPU, oor_count -> 0.
  - Held registered read address and held readdata -> 0.
  - While reset_n is low, both waitrequests = 1, ram_wren = 0 and both readdata outputs = 0.
  - This applies mid-read too: an in-flight read is abandoned, no completion is signalled, and the master must re-issue it.
- Avalon rules: a master holds address, data and command stable while its waitrequest = 1. A transfer completes in the cycle its waitrequest = 0.
- States: IDLE, RD_BUSY.
- IDLE, neither port requesting: both waitrequests = 0 (idle-low is harmless), ram_wren = 0.
- IDLE, arbitration (combinational):
  - Only one port requesting -> that port is granted.
  - Both requesting, HOST_PRIORITY=1 -> host granted.
  - Both requesting, HOST_PRIORITY=0 -> the port not granted last time wins; the rr pointer updates on every grant.
  - The losing port sees waitrequest = 1.
- Granted write:
  - Completes in the grant cycle: waitrequest = 0 and ram_wren = 1.
  - Host byteena = all ones. CPU byteena = cpu_byteenable.
  - State stays IDLE, so back-to-back writes run at 1 per cycle.
- Out-of-range CPU write: ram_wren = 0, the write completes normally, and oor_count increments.
- Granted read:
  - Grant cycle: ram_rdaddress is driven combinationally from the granted address; the address and owner are registered; waitrequest = 1; go to RD_BUSY with counter = 1.
- RD_BUSY:
  - Both waitrequests = 1 except the completion cycle.
  - ram_rdaddress = held address.
  - Counter increments each cycle.
  - When the counter reaches RD_LATENCY: owner waitrequest = 0, owner readdata = ram_q; return to IDLE.
  - New grants are evaluated from the following cycle.
  - Net effect: a read takes RD_LATENCY+1 request cycles; with RD_LATENCY=1 this is 2 cycles (waitrequest high, then low).
- Out-of-range CPU read: same timing, but cpu_readdata = 0 at completion and oor_count increments.
- Readdata outputs are 0 outside their completion cycle.
- Simultaneous read and write from one master: treated as a write; the read is ignored.
- oor_count:
  - Saturates at 16'hFFFF.
  - oor_clr has priority over an increment in the same cycle; the result is 0.
- Arithmetic:
  - Counter width 3 bits (fits RD_LATENCY max 4).
  - Host address used unmodified. CPU low A_LSB bits ignored.

Decomposition:
- Shared include core_mem_defs.vh holds:
  - State encodings (IDLE=1'b0, RD_BUSY=1'b1).
  - Owner encodings (OWN_CPU=0, OWN_HOST=1).
  - A clog2 constant function.
  - RD_LATENCY range check (elaboration error if out of range).
- One sub-module, core_mem_rr_arb: 2-requester arbiter with HOST_PRIORITY mode, grant output and rr pointer register.

Test Plan:
1. Reset and idle: hold reset_n low 3 cycles with cpu_read=1 -> cpu_waitrequest=1, ram_wren=0, oor_count=0.
2. Basic access, RD_LATENCY=1: CPU write 0xDEADBEEF, be=4'b0011, to 0x10, then CPU read 0x10 -> ram_wren pulses 1 cycle with ram_wraddress=4 and byteena=4'b0011; read waitrequest is high 1 cycle then low, with cpu_readdata=ram_q.
3. Longer latency, RD_LATENCY=3: host read of address 7 -> host_waitrequest high 3 cycles, low on 4th; ram_rdaddress=7 held throughout.
4. Contention, HOST_PRIORITY=0:
   - Both ports write continuously for 6 cycles -> grants alternate CPU, host, CPU, ...
   - With HOST_PRIORITY=1 -> host is granted all 6 cycles.
5. Out-of-range: CPU write to 0x0001_0000 (ADDR_WIDTH=12) -> no ram_wren; oor_count=1. CPU read of the same address -> readdata=0; oor_count=2. Pulse oor_clr -> 0.
6. Reset mid-read: RD_LATENCY=4, assert reset_n low at busy cycle 2 -> no completion; after release, state is IDLE and a re-issued read completes in 5 cycles.

Source files
------------

// File: rtl/core_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// core_mem_arb_pkg
// Shared definitions for the memory arbiter slice: FSM state and owner
// encodings, latency counter width and a clog2 constant function.
// -----------------------------------------------------------------------------
package core_mem_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_BUSY = 1'b1
   } state_t;

   typedef enum logic {
      OWN_CPU  = 1'b0,
      OWN_HOST = 1'b1
   } owner_t;

   // Latency counter width; RD_LATENCY is limited to 1..4.
   localparam int CNT_W = 3;

   // Ceiling log2 for elaboration-time constants.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/core_mem_rr_arb.sv
// -----------------------------------------------------------------------------
// core_mem_rr_arb
// Two-requester arbiter (CPU vs host). With HOST_PRIORITY != 0 the host wins
// contention; otherwise the port not favoured last time wins (round-robin).
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   en              arbitration allowed this cycle
//   cpu_req         CPU is requesting
//   host_req        host is requesting
//   grant_valid     a grant is issued this cycle
//   grant           owner of the grant
// -----------------------------------------------------------------------------
module core_mem_rr_arb
   import core_mem_arb_pkg::*;
#(
   parameter int HOST_PRIORITY = 1
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   en,
   input  logic   cpu_req,
   input  logic   host_req,
   output logic   grant_valid,
   output owner_t grant
);

   // Port favoured at the next contention; flipped away from every winner.
   owner_t rr_ptr;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      grant_valid = en & (cpu_req | host_req);
      grant       = OWN_CPU;
      if (host_req && !cpu_req) begin
         grant = OWN_HOST;
      end else if (host_req && cpu_req) begin
         grant = (HOST_PRIORITY != 0) ? OWN_HOST : rr_ptr;
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr <= OWN_CPU;
      end else if (grant_valid) begin
         rr_ptr <= owner_t'(~grant);
      end
   end

endmodule

// File: rtl/core_mem_arb.sv
// -----------------------------------------------------------------------------
// core_mem_arb
// Arbitrates a CPU data port (byte address + byte enables) and a host CSR
// port (word address) onto one simple dual-port RAM with RD_LATENCY read
// latency. Writes complete in the grant cycle; reads hold the RAM read
// address until ram_q is valid. CPU accesses above the RAM are dropped and
// counted in a saturating counter.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   cpu_*                             Avalon-style CPU data port
//   host_*                            Avalon-style host CSR port
//   ram_wren/byteena/wraddress/data   RAM write port
//   ram_rdaddress, ram_q              RAM read port
//   oor_clr, oor_count                clear / count of out-of-range accesses
// -----------------------------------------------------------------------------
module core_mem_arb
   import core_mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH    = 12,
   parameter int DATA_WIDTH    = 32,
   parameter int RD_LATENCY    = 1,
   parameter int HOST_PRIORITY = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [31:0]             cpu_address,
   input  logic                    cpu_read,
   input  logic                    cpu_write,
   input  logic [DATA_WIDTH-1:0]   cpu_writedata,
   input  logic [DATA_WIDTH/8-1:0] cpu_byteenable,
   output logic [DATA_WIDTH-1:0]   cpu_readdata,
   output logic                    cpu_waitrequest,
   input  logic [ADDR_WIDTH-1:0]   host_address,
   input  logic                    host_read,
   input  logic                    host_write,
   input  logic [DATA_WIDTH-1:0]   host_writedata,
   output logic [DATA_WIDTH-1:0]   host_readdata,
   output logic                    host_waitrequest,
   output logic                    ram_wren,
   output logic [DATA_WIDTH/8-1:0] ram_byteena,
   output logic [ADDR_WIDTH-1:0]   ram_wraddress,
   output logic [DATA_WIDTH-1:0]   ram_data,
   output logic [ADDR_WIDTH-1:0]   ram_rdaddress,
   input  logic [DATA_WIDTH-1:0]   ram_q,
   input  logic                    oor_clr,
   output logic [15:0]             oor_count
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int A_LSB = clog2(BE_W);
   localparam int A_HI  = ADDR_WIDTH + A_LSB;
   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(RD_LATENCY);

   if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("core_mem_arb: RD_LATENCY must be in 1..4");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("core_mem_arb: DATA_WIDTH must be a multiple of 8");
   end

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [ADDR_WIDTH-1:0]  held_addr;
   owner_t                 held_owner;
   logic                   held_oor;

   logic                   cpu_req, host_req;
   logic                   cpu_oor;
   logic [ADDR_WIDTH-1:0]  cpu_word;
   logic                   grant_valid;
   owner_t                 grant;
   logic                   grant_wr;
   logic                   grant_rd;
   logic                   rd_done;
   logic                   oor_inc;

   assign cpu_req  = cpu_read  | cpu_write;
   assign host_req = host_read | host_write;
   assign cpu_word = cpu_address[A_HI-1:A_LSB];
   assign cpu_oor  = (cpu_address >> A_HI) != 32'd0;

   core_mem_rr_arb #(
      .HOST_PRIORITY (HOST_PRIORITY)
   ) u_arb (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (reset_n && state == IDLE),
      .cpu_req     (cpu_req),
      .host_req    (host_req),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // A simultaneous read and write from one master is taken as a write.
   assign grant_wr = grant_valid && ((grant == OWN_CPU) ? cpu_write : host_write);
   assign grant_rd = grant_valid && !grant_wr;
   assign rd_done  = reset_n && state == RD_BUSY && cnt == LAT_CNT;
   assign oor_inc  = grant_valid && grant == OWN_CPU && cpu_oor;

   always_comb begin
      cpu_waitrequest  = 1'b0;
      host_waitrequest = 1'b0;
      cpu_readdata     = '0;
      host_readdata    = '0;
      ram_wren         = 1'b0;
      ram_byteena      = '0;
      ram_wraddress    = '0;
      ram_data         = '0;
      ram_rdaddress    = held_addr;
      if (!reset_n) begin
         cpu_waitrequest  = 1'b1;
         host_waitrequest = 1'b1;
      end else if (state == IDLE) begin
         if (grant_valid) begin
            // Loser stalls; winner stalls only while its read is pending.
            if (grant == OWN_CPU) begin
               host_waitrequest = host_req;
               cpu_waitrequest  = grant_rd;
               ram_wren         = grant_wr && !cpu_oor;
               ram_byteena      = cpu_byteenable;
               ram_wraddress    = cpu_word;
               ram_data         = cpu_writedata;
               if (grant_rd) ram_rdaddress = cpu_word;
            end else begin
               cpu_waitrequest  = cpu_req;
               host_waitrequest = grant_rd;
               ram_wren         = grant_wr;
               ram_byteena      = '1;
               ram_wraddress    = host_address;
               ram_data         = host_writedata;
               if (grant_rd) ram_rdaddress = host_address;
            end
         end
      end else begin
         cpu_waitrequest  = 1'b1;
         host_waitrequest = 1'b1;
         if (rd_done) begin
            if (held_owner == OWN_CPU) begin
               cpu_waitrequest = 1'b0;
               cpu_readdata    = held_oor ? '0 : ram_q;
            end else begin
               host_waitrequest = 1'b0;
               host_readdata    = ram_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         held_addr  <= '0;
         held_owner <= OWN_CPU;
         held_oor   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_rd) begin
                  held_addr  <= (grant == OWN_CPU) ? cpu_word : host_address;
                  held_owner <= grant;
                  held_oor   <= (grant == OWN_CPU) && cpu_oor;
                  cnt        <= CNT_W'(1);
                  state      <= RD_BUSY;
               end
            end
            RD_BUSY: begin
               if (cnt == LAT_CNT) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Clear wins over a same-cycle increment; the count sticks at all ones.
   always_ff @(posedge clk) begin
      if (!reset_n || oor_clr) begin
         oor_count <= '0;
      end else if (oor_inc && oor_count != 16'hFFFF) begin
         oor_count <= oor_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_core_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_core_mem_arb
// Three arbiter instances share one stimulus set:
//   inst 0: RD_LATENCY=1, HOST_PRIORITY=0 (round-robin)
//   inst 1: RD_LATENCY=3, HOST_PRIORITY=1
//   inst 2: RD_LATENCY=4, HOST_PRIORITY=1
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_core_mem_arb;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] cpu_address;
   logic        cpu_read, cpu_write;
   logic [31:0] cpu_writedata;
   logic [3:0]  cpu_byteenable;
   logic [11:0] host_address;
   logic        host_read, host_write;
   logic [31:0] host_writedata;
   logic [31:0] ram_q;
   logic        oor_clr;

   logic [31:0] cpu_readdata     [N];
   logic        cpu_waitrequest  [N];
   logic [31:0] host_readdata    [N];
   logic        host_waitrequest [N];
   logic        ram_wren         [N];
   logic [3:0]  ram_byteena      [N];
   logic [11:0] ram_wraddress    [N];
   logic [31:0] ram_data         [N];
   logic [11:0] ram_rdaddress    [N];
   logic [15:0] oor_count        [N];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      core_mem_arb #(
         .ADDR_WIDTH    (12),
         .DATA_WIDTH    (32),
         .RD_LATENCY    ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
         .HOST_PRIORITY ((g == 0) ? 0 : 1)
      ) dut (
         .clk              (clk),
         .reset_n          (reset_n),
         .cpu_address      (cpu_address),
         .cpu_read         (cpu_read),
         .cpu_write        (cpu_write),
         .cpu_writedata    (cpu_writedata),
         .cpu_byteenable   (cpu_byteenable),
         .cpu_readdata     (cpu_readdata[g]),
         .cpu_waitrequest  (cpu_waitrequest[g]),
         .host_address     (host_address),
         .host_read        (host_read),
         .host_write       (host_write),
         .host_writedata   (host_writedata),
         .host_readdata    (host_readdata[g]),
         .host_waitrequest (host_waitrequest[g]),
         .ram_wren         (ram_wren[g]),
         .ram_byteena      (ram_byteena[g]),
         .ram_wraddress    (ram_wraddress[g]),
         .ram_data         (ram_data[g]),
         .ram_rdaddress    (ram_rdaddress[g]),
         .ram_q            (ram_q),
         .oor_clr          (oor_clr),
         .oor_count        (oor_count[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cpu_address    = 32'h0;
      cpu_read       = 1'b0;
      cpu_write      = 1'b0;
      cpu_writedata  = 32'h0;
      cpu_byteenable = 4'h0;
      host_address   = 12'h0;
      host_read      = 1'b0;
      host_write     = 1'b0;
      host_writedata = 32'h0;
      oor_clr        = 1'b0;
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      cyc();
      cyc();
      reset_n = 1'b1;
   endtask

   initial begin
      idle_inputs();
      ram_q   = 32'hCAFE_F00D;
      reset_n = 1'b0;
      #1;

      // 1. Reset with requests pending: everything stalled, no writes.
      cpu_read   = 1'b1;
      host_write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         check($sformatf("rst_cpu_wait_%0d", i), 32'(cpu_waitrequest[0]), 32'd1);
         check($sformatf("rst_host_wait_%0d", i), 32'(host_waitrequest[0]), 32'd1);
         check($sformatf("rst_wren_%0d", i), 32'(ram_wren[0]), 32'd0);
         check($sformatf("rst_cpu_rdata_%0d", i), cpu_readdata[0], 32'd0);
         cyc();
      end
      check("rst_oor_count", 32'(oor_count[0]), 32'd0);

      // 2. Basic CPU write then read, RD_LATENCY=1 (inst 0).
      idle_inputs();
      reset_n = 1'b1;
      cyc();
      cpu_write      = 1'b1;
      cpu_address    = 32'h0000_0010;
      cpu_writedata  = 32'hDEAD_BEEF;
      cpu_byteenable = 4'b0011;
      sample();
      check("wr_wren", 32'(ram_wren[0]), 32'd1);
      check("wr_addr", 32'(ram_wraddress[0]), 32'd4);
      check("wr_be", 32'(ram_byteena[0]), 32'h3);
      check("wr_data", ram_data[0], 32'hDEAD_BEEF);
      check("wr_wait", 32'(cpu_waitrequest[0]), 32'd0);
      cyc();
      cpu_write = 1'b0;
      cpu_read  = 1'b1;
      sample();
      check("rd1_wren_off", 32'(ram_wren[0]), 32'd0);
      check("rd1_wait_c0", 32'(cpu_waitrequest[0]), 32'd1);
      check("rd1_rdaddr_c0", 32'(ram_rdaddress[0]), 32'd4);
      check("rd1_rdata_c0", cpu_readdata[0], 32'd0);
      cyc();
      sample();
      check("rd1_wait_c1", 32'(cpu_waitrequest[0]), 32'd0);
      check("rd1_rdata_c1", cpu_readdata[0], 32'hCAFE_F00D);
      check("rd1_rdaddr_c1", 32'(ram_rdaddress[0]), 32'd4);
      cyc();
      cpu_read = 1'b0;
      sample();
      check("rd1_rdata_after", cpu_readdata[0], 32'd0);

      // 3. Host read with RD_LATENCY=3 (inst 1).
      do_reset();
      host_read    = 1'b1;
      host_address = 12'd7;
      for (int k = 0; k < 4; k++) begin
         sample();
         check($sformatf("rd3_wait_%0d", k), 32'(host_waitrequest[1]), (k < 3) ? 32'd1 : 32'd0);
         check($sformatf("rd3_rdaddr_%0d", k), 32'(ram_rdaddress[1]), 32'd7);
         check($sformatf("rd3_rdata_%0d", k), host_readdata[1], (k == 3) ? 32'hCAFE_F00D : 32'd0);
         cyc();
      end
      host_read = 1'b0;

      // 4. Both ports writing continuously: round-robin vs host priority.
      do_reset();
      cpu_write      = 1'b1;
      cpu_address    = 32'h0000_0020;
      cpu_writedata  = 32'h1111_1111;
      cpu_byteenable = 4'hF;
      host_write     = 1'b1;
      host_address   = 12'd9;
      host_writedata = 32'h2222_2222;
      for (int k = 0; k < 6; k++) begin
         sample();
         check($sformatf("rr_cpu_wait_%0d", k), 32'(cpu_waitrequest[0]), (k % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("rr_host_wait_%0d", k), 32'(host_waitrequest[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rr_wraddr_%0d", k), 32'(ram_wraddress[0]), (k % 2 == 0) ? 32'd8 : 32'd9);
         check($sformatf("hp_cpu_wait_%0d", k), 32'(cpu_waitrequest[1]), 32'd1);
         check($sformatf("hp_host_wait_%0d", k), 32'(host_waitrequest[1]), 32'd0);
         check($sformatf("hp_be_%0d", k), 32'(ram_byteena[1]), 32'hF);
         cyc();
      end

      // 5. Out-of-range CPU accesses and counter clear (inst 0).
      do_reset();
      cpu_write      = 1'b1;
      cpu_address    = 32'h0001_0000;
      cpu_writedata  = 32'h5555_5555;
      cpu_byteenable = 4'hF;
      sample();
      check("oor_wr_wren", 32'(ram_wren[0]), 32'd0);
      check("oor_wr_wait", 32'(cpu_waitrequest[0]), 32'd0);
      cyc();
      cpu_write = 1'b0;
      cpu_read  = 1'b1;
      sample();
      check("oor_count_1", 32'(oor_count[0]), 32'd1);
      check("oor_rd_wait_c0", 32'(cpu_waitrequest[0]), 32'd1);
      cyc();
      sample();
      check("oor_rd_wait_c1", 32'(cpu_waitrequest[0]), 32'd0);
      check("oor_rd_rdata", cpu_readdata[0], 32'd0);
      cyc();
      cpu_read = 1'b0;
      sample();
      check("oor_count_2", 32'(oor_count[0]), 32'd2);
      cyc();
      oor_clr = 1'b1;
      cyc();
      oor_clr = 1'b0;
      sample();
      check("oor_count_clr", 32'(oor_count[0]), 32'd0);

      // 6. Reset in the middle of a RD_LATENCY=4 read (inst 2).
      do_reset();
      host_read    = 1'b1;
      host_address = 12'd5;
      sample();
      check("mid_grant_wait", 32'(host_waitrequest[2]), 32'd1);
      cyc();
      sample();
      check("mid_busy1_wait", 32'(host_waitrequest[2]), 32'd1);
      cyc();
      reset_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sample();
         check($sformatf("mid_rst_wait_%0d", k), 32'(host_waitrequest[2]), 32'd1);
         check($sformatf("mid_rst_rdata_%0d", k), host_readdata[2], 32'd0);
         cyc();
      end
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         sample();
         check($sformatf("reissue_wait_%0d", k), 32'(host_waitrequest[2]), (k < 4) ? 32'd1 : 32'd0);
         check($sformatf("reissue_rdaddr_%0d", k), 32'(ram_rdaddress[2]), 32'd5);
         check($sformatf("reissue_rdata_%0d", k), host_readdata[2], (k == 4) ? 32'hCAFE_F00D : 32'd0);
         cyc();
      end
      host_read = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
